// File: rtl/parity_arb_ctrl.sv
// Two-requester round-robin arbiter that computes per-nibble even parity
// of the granted word, one nibble per cycle, and holds the result until accepted.
module parity_arb_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic [4*NIBBLES-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [4*NIBBLES-1:0] req1_data,
  output logic                 req1_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [4*NIBBLES-1:0] rsp_data,
  output logic [NIBBLES-1:0]   rsp_parity,
  output logic                 rsp_word_parity,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [W-1:0]       data_q, data_d;
  logic [NIBBLES-1:0] parity_q, parity_d;
  logic               id_q, id_d;

  logic               grant_id;
  logic               can_accept;
  logic [3:0]         nibble;

  // The pointer only breaks ties; a lone requester is always granted.
  always_comb begin
    grant_id = ptr_q;
    if (req0_valid && !req1_valid) begin
      grant_id = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant_id = 1'b1;
    end
  end

  assign can_accept = rst_n && (state_q == IDLE);
  assign req0_ready = can_accept && req0_valid && !grant_id;
  assign req1_ready = can_accept && req1_valid && grant_id;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    parity_d = parity_q;
    id_d     = id_q;
    nibble   = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (cnt_q == CW'(i)) begin
        nibble = data_q[4*i +: 4];
      end
    end
    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          data_d   = grant_id ? req1_data : req0_data;
          id_d     = grant_id;
          ptr_d    = ~grant_id;
          cnt_d    = '0;
          parity_d = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (cnt_q == CW'(i)) begin
            parity_d[i] = ^nibble;
          end
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NIBBLES - 1)) begin
          cnt_d   = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      cnt_q    <= '0;
      data_q   <= '0;
      parity_q <= '0;
      id_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      parity_q <= parity_d;
      id_q     <= id_d;
    end
  end

  assign rsp_valid       = (state_q == RESP);
  assign busy            = (state_q != IDLE);
  assign rsp_id          = id_q;
  assign rsp_data        = data_q;
  assign rsp_parity      = parity_q;
  assign rsp_word_parity = ^parity_q;

endmodule

// File: tb/tb_parity_arb_ctrl.sv
// Self-checking bench for parity_arb_ctrl (NIBBLES = 4) using a parity
// reference computed from bit counts and a queue-based response scoreboard.
module tb_parity_arb_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req0_valid, req1_valid, rsp_ready;
  logic [W-1:0]   req0_data, req1_data;
  logic           req0_ready, req1_ready;
  logic           rsp_valid, rsp_id, rsp_word_parity, busy;
  logic [W-1:0]   rsp_data;
  logic [NIB-1:0] rsp_parity;

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
  } txn_t;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  parity_arb_ctrl #(.NIBBLES(NIB)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req0_valid     (req0_valid),
    .req0_data      (req0_data),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_data      (req1_data),
    .req1_ready     (req1_ready),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_id         (rsp_id),
    .rsp_data       (rsp_data),
    .rsp_parity     (rsp_parity),
    .rsp_word_parity(rsp_word_parity),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Bit i is odd/even count of ones in nibble i.
  function automatic logic [NIB-1:0] ref_parity(input logic [W-1:0] d);
    logic [NIB-1:0] p;
    for (int i = 0; i < NIB; i++) begin
      p[i] = (($countones((d >> (4 * i)) & 16'hF) % 2) == 1);
    end
    return p;
  endfunction

  function automatic logic ref_word(input logic [W-1:0] d);
    return ($countones(d) % 2) == 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 16'hA5A5;
    req1_data  = 16'h5A5A;
    rsp_ready  = 1'b1;
    #1;
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready_pre: got %b expected 00", {req0_ready, req1_ready});
    end
    tick();
    tick();
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready_held: got %b expected 00", {req0_ready, req1_ready});
    end
    rst_n      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    #1;
    tests_run++;
    if ({rsp_valid, busy, rsp_id, rsp_word_parity, req0_ready, req1_ready} !== 6'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl_outs: got %b expected 000000",
               {rsp_valid, busy, rsp_id, rsp_word_parity, req0_ready, req1_ready});
    end
    tests_run++;
    if ({rsp_data, rsp_parity} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data_outs: got %h/%b expected 0/0", rsp_data, rsp_parity);
    end
  endtask

  task automatic test_single();
    req0_valid = 1'b1;
    req0_data  = 16'h0001;
    #1;
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL single_ready: got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0;
    for (int k = 1; k <= NIB; k++) begin
      #1;
      tests_run++;
      if ({rsp_valid, busy} !== 2'b01) begin
        tests_failed++;
        $display("[TB] FAIL single_calc_%0d: got valid/busy %b expected 01", k, {rsp_valid, busy});
      end
      tick();
    end
    tests_run++;
    if (rsp_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_latency: got rsp_valid %b expected 1", rsp_valid);
    end
    tests_run++;
    if ({rsp_id, rsp_data, rsp_parity, rsp_word_parity} !== {1'b0, 16'h0001, 4'b0001, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL single_result: got id %b data %h par %b wp %b expected 0 0001 0001 1",
               rsp_id, rsp_data, rsp_parity, rsp_word_parity);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    tests_run++;
    if ({rsp_valid, busy} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL single_return_idle: got valid/busy %b expected 00", {rsp_valid, busy});
    end
  endtask

  task automatic test_both_valid();
    int n;
    do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 16'hFFFF;
    req1_data  = 16'h7000;
    rsp_ready  = 1'b1;
    #1;
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL both_first_grant: got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    tests_run++;
    if (n !== NIB) begin
      tests_failed++;
      $display("[TB] FAIL both_latency0: got %0d cycles expected %0d", n, NIB);
    end
    tests_run++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_parity, rsp_word_parity} !== {1'b1, 1'b0, 16'hFFFF, 4'b0000, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL both_result0: got v %b id %b data %h par %b wp %b expected 1 0 ffff 0000 0",
               rsp_valid, rsp_id, rsp_data, rsp_parity, rsp_word_parity);
    end
    tick();
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL both_second_grant: got %b expected 01", {req0_ready, req1_ready});
    end
    tick();
    req1_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    tests_run++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_parity, rsp_word_parity} !== {1'b1, 1'b1, 16'h7000, 4'b1000, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL both_result1: got v %b id %b data %h par %b wp %b expected 1 1 7000 1000 1",
               rsp_valid, rsp_id, rsp_data, rsp_parity, rsp_word_parity);
    end
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [W-1:0] d0, d1;
    int           n;
    d0         = W'($urandom);
    d1         = W'($urandom);
    req0_valid = 1'b1;
    req0_data  = d0;
    rsp_ready  = 1'b0;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_data  = d1;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_parity, rsp_word_parity, req1_ready} !==
          {1'b1, 1'b0, d0, ref_parity(d0), ref_word(d0), 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold_%0d: got v %b id %b data %h par %b wp %b rdy1 %b expected 1 0 %h %b %b 0",
                 k, rsp_valid, rsp_id, rsp_data, rsp_parity, rsp_word_parity, req1_ready,
                 d0, ref_parity(d0), ref_word(d0));
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    tests_run++;
    if ({rsp_valid, req1_ready} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL stall_release: got valid/rdy1 %b expected 10", {rsp_valid, req1_ready});
    end
    tick();
    tests_run++;
    if (req1_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL stall_next_accept: got req1_ready %b expected 1", req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    tests_run++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_parity} !== {1'b1, 1'b1, d1, ref_parity(d1)}) begin
      tests_failed++;
      $display("[TB] FAIL stall_result1: got v %b id %b data %h par %b expected 1 1 %h %b",
               rsp_valid, rsp_id, rsp_data, rsp_parity, d1, ref_parity(d1));
    end
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_calc();
    logic [W-1:0] d1;
    int           n;
    int           spurious;
    req0_valid = 1'b1;
    req0_data  = 16'h1234;
    rsp_ready  = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    tests_run++;
    if ({busy, rsp_valid} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL midcalc_abandon: got busy/valid %b expected 00", {busy, rsp_valid});
    end
    spurious = 0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid) spurious++;
      tick();
    end
    tests_run++;
    if (spurious !== 0) begin
      tests_failed++;
      $display("[TB] FAIL midcalc_no_rsp: got %0d response cycles expected 0", spurious);
    end
    d1         = W'($urandom);
    req1_valid = 1'b1;
    req1_data  = d1;
    #1;
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL midcalc_req1_grant: got %b expected 01", {req0_ready, req1_ready});
    end
    tick();
    req1_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    tests_run++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_parity} !== {1'b1, 1'b1, d1, ref_parity(d1)}) begin
      tests_failed++;
      $display("[TB] FAIL midcalc_result: got v %b id %b data %h par %b expected 1 1 %h %b",
               rsp_valid, rsp_id, rsp_data, rsp_parity, d1, ref_parity(d1));
    end
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    txn_t q[$];
    txn_t e;
    int   last_acc;
    int   accepts;
    last_acc   = -1;
    accepts    = 0;
    rsp_ready  = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    for (int k = 0; k < 80; k++) begin
      req1_data = W'($urandom);
      #1;
      if (rsp_valid) begin
        e = q.pop_front();
        tests_run++;
        if ({rsp_id, rsp_data, rsp_parity, rsp_word_parity} !== {e.id, e.data, ref_parity(e.data), ref_word(e.data)}) begin
          tests_failed++;
          $display("[TB] FAIL b2b_result: got id %b data %h par %b wp %b expected %b %h %b %b",
                   rsp_id, rsp_data, rsp_parity, rsp_word_parity,
                   e.id, e.data, ref_parity(e.data), ref_word(e.data));
        end
      end
      if (req1_ready) begin
        if (last_acc >= 0) begin
          tests_run++;
          if (cyc - last_acc !== NIB + 2) begin
            tests_failed++;
            $display("[TB] FAIL b2b_period: got %0d cycles expected %0d", cyc - last_acc, NIB + 2);
          end
        end
        last_acc = cyc;
        accepts++;
        q.push_back('{id: 1'b1, data: req1_data});
      end
      tick();
    end
    req1_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid && q.size() > 0) begin
        e = q.pop_front();
        tests_run++;
        if ({rsp_id, rsp_data, rsp_parity} !== {e.id, e.data, ref_parity(e.data)}) begin
          tests_failed++;
          $display("[TB] FAIL b2b_drain: got id %b data %h par %b expected %b %h %b",
                   rsp_id, rsp_data, rsp_parity, e.id, e.data, ref_parity(e.data));
        end
      end
      tick();
    end
    tests_run++;
    if (q.size() !== 0 || accepts < 12) begin
      tests_failed++;
      $display("[TB] FAIL b2b_count: got %0d accepts %0d unanswered expected >=12 and 0", accepts, q.size());
    end
    rsp_ready = 1'b0;
  endtask

  // Traffic with a scoreboard queue; hold_both keeps both requesters valid.
  task automatic run_traffic(input int ncycles, input bit hold_both,
                             output int grants0, output int grants1);
    txn_t q[$];
    txn_t e;
    logic last_id;
    logic exp_id;
    logic in_flight;
    logic prev_valid;
    int   acc_cyc;
    do_reset();
    last_id    = 1'b1;
    in_flight  = 1'b0;
    prev_valid = 1'b0;
    acc_cyc    = 0;
    grants0    = 0;
    grants1    = 0;
    for (int k = 0; k < ncycles + 20; k++) begin
      if (k < ncycles) begin
        req0_valid = hold_both ? 1'b1 : ($urandom_range(0, 2) != 0);
        req1_valid = hold_both ? 1'b1 : ($urandom_range(0, 2) != 0);
        rsp_ready  = hold_both ? 1'b1 : ($urandom_range(0, 1) != 0);
      end else begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
      end
      req0_data = W'($urandom);
      req1_data = W'($urandom);
      #1;
      if (req0_ready && req1_ready) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL traffic_dual_ready: got 11 expected at most one");
      end
      if (rsp_valid) begin
        tests_run++;
        if (q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL traffic_spurious_rsp: got rsp_valid 1 expected 0");
        end else begin
          e = q[0];
          if ({rsp_id, rsp_data, rsp_parity, rsp_word_parity} !== {e.id, e.data, ref_parity(e.data), ref_word(e.data)}) begin
            tests_failed++;
            $display("[TB] FAIL traffic_result: got id %b data %h par %b wp %b expected %b %h %b %b",
                     rsp_id, rsp_data, rsp_parity, rsp_word_parity,
                     e.id, e.data, ref_parity(e.data), ref_word(e.data));
          end
        end
        if (!prev_valid) begin
          tests_run++;
          if (cyc - acc_cyc !== NIB + 1) begin
            tests_failed++;
            $display("[TB] FAIL traffic_latency: got %0d cycles expected %0d", cyc - acc_cyc, NIB + 1);
          end
        end
        if (rsp_ready && q.size() > 0) begin
          void'(q.pop_front());
          in_flight = 1'b0;
        end
      end
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        exp_id = (req0_valid && req1_valid) ? !last_id : req1_valid;
        tests_run++;
        if (req1_ready !== exp_id || in_flight) begin
          tests_failed++;
          $display("[TB] FAIL traffic_grant: got id %b in_flight %b expected id %b in_flight 0",
                   req1_ready, in_flight, exp_id);
        end
        e.id   = req1_ready;
        e.data = req1_ready ? req1_data : req0_data;
        q.push_back(e);
        if (req1_ready) grants1++; else grants0++;
        last_id   = req1_ready;
        in_flight = 1'b1;
        acc_cyc   = cyc;
      end
      prev_valid = rsp_valid;
      tick();
    end
    tests_run++;
    if (q.size() !== 0 || in_flight) begin
      tests_failed++;
      $display("[TB] FAIL traffic_unanswered: got %0d pending expected 0", q.size());
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    int g0, g1;
    run_traffic(10000, 1'b0, g0, g1);
    tests_run++;
    if (g0 < 100 || g1 < 100) begin
      tests_failed++;
      $display("[TB] FAIL random_activity: got grants %0d/%0d expected >=100 each", g0, g1);
    end
    run_traffic(240, 1'b1, g0, g1);
    tests_run++;
    if (g0 < 15 || g1 < 15 || (g0 - g1) > 1 || (g1 - g0) > 1) begin
      tests_failed++;
      $display("[TB] FAIL held_fairness: got grants %0d/%0d expected balanced >=15 each", g0, g1);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;
    rsp_ready  = 1'b0;
    test_reset();
    test_single();
    test_both_valid();
    test_stall();
    test_reset_mid_calc();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/parity_arb_ctrl.md
PARITY_ARB_CTRL -- requirements
Module: parity_arb_ctrl

Interface
REQ-001 The block SHALL have one parameter: NIBBLES, default 4, number of 4-bit nibbles per word (legal 2..8); W = 4*NIBBLES.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has a word to protect.
REQ-005 req0_data  input  W  requester 0 word.
REQ-006 req0_ready  output  1  requester 0 word accepted this cycle.
REQ-007 req1_valid  input  1  requester 1 has a word to protect.
REQ-008 req1_data  input  W  requester 1 word.
REQ-009 req1_ready  output  1  requester 1 word accepted this cycle.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer accepts result.
REQ-012 rsp_id  output  1  requester index of the result.
REQ-013 rsp_data  output  W  captured word, unmodified.
REQ-014 rsp_parity  output  NIBBLES  bit i = even-parity bit (XOR of the 4 bits) of nibble i, where nibble i = data[4i+3:4i].
REQ-015 rsp_word_parity  output  1  XOR of all rsp_parity bits.
REQ-016 busy  output  1  high whenever state != IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, CALC, RESP.
REQ-018 Arbitration:
- In IDLE, with any reqN_valid high, the block SHALL grant one requester.
- Grant order is round-robin via a 1-bit pointer.
- Both valid: grant the pointer's requester.
- One valid: grant that requester.
REQ-019 readyN SHALL be combinational: high only in IDLE for the granted requester, and never for both in the same cycle.
REQ-020 readyN SHALL NOT depend on rsp_ready.
REQ-021 On handshake (validN & readyN):
- capture dataN and id N;
- set pointer to the other requester;
- clear the nibble counter and the parity register;
- enter CALC.
REQ-022 In CALC, each cycle the block SHALL compute the 4-bit XOR of nibble[cnt] into parity[cnt] and increment cnt.
REQ-023 The block SHALL leave CALC for RESP after cnt = NIBBLES-1 has been processed (exactly NIBBLES cycles in CALC).
REQ-024 A single 4-bit XOR SHALL be used per cycle; no full-word parity tree.
REQ-025 In RESP, rsp_valid SHALL be high, and rsp_id/rsp_data/rsp_parity/rsp_word_parity SHALL be stable until the rsp_valid & rsp_ready cycle.
REQ-026 After the rsp_valid & rsp_ready cycle the block SHALL return to IDLE.
REQ-027 Latency: handshake in cycle T -> rsp_valid high in cycle T+1+NIBBLES.
REQ-028 Throughput: with rsp_ready held high, the minimum acceptance period SHALL be NIBBLES+2 cycles.
REQ-029 Outside RESP, rsp_valid SHALL be 0; rsp_* data outputs MAY hold stale values.
REQ-030 Requester valid dropping before grant SHALL be tolerated (no grant issued, no state change).
REQ-031 A request raised while not in IDLE SHALL wait; readyN stays 0.
REQ-032 rsp_ready high on RESP entry SHALL complete RESP in one cycle.
REQ-033 rsp_ready asserted outside RESP SHALL have no effect.

Reset
REQ-034 While rst_n = 0 at a clock edge, the block SHALL set: state = IDLE, pointer = requester 0, cnt = 0, captured data/parity/id = 0.
REQ-035 The cycle after reset, all outputs SHALL be 0.
REQ-036 Reset in any state, including mid-CALC or RESP with rsp_ready low, SHALL abandon the in-flight word with no response.
REQ-037 During reset, readyN SHALL be 0.

Verification (NIBBLES = 4)
REQ-038 req0_valid alone, req0_data = 16'h0001, accepted at T -> rsp_valid at T+5, rsp_id = 0, rsp_parity = 4'b0001, rsp_word_parity = 1.
REQ-039 After reset, both valid, req0_data = 16'hFFFF, req1_data = 16'h7000, rsp_ready = 1 -> req0 served first (parity 4'b0000, word parity 0), then req1 (parity 4'b1000, word parity 1).
REQ-040 rsp_ready low for 3 cycles in RESP with req1_valid high -> rsp_* stable, req1_ready = 0 throughout, req1 accepted the cycle after the RESP handshake.
REQ-041 rst_n low for one cycle during the 2nd CALC cycle -> next cycle busy = 0, rsp_valid = 0, no response for that word; a req1 request then accepted with rsp_id = 1.
REQ-042 req1_valid held high with varying data, rsp_ready = 1 -> req1_ready pulses every 6 cycles; each result matches a per-nibble XOR reference model.
REQ-043 Randomised valid/ready/data on both requesters over 10k cycles -> every accepted word answered exactly once, in acceptance order, with correct id and parity; neither requester starved when both are held valid.
